// File: rtl/chain_fifo.sv
// chain_fifo: first-word-fall-through FIFO between the buffer/and2 gate
// chain and its downstream consumer. Pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate counter.
// Optional occupancy output is enabled with CHAIN_FIFO_LEVEL_EN.
module chain_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef CHAIN_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty, full, push, pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Handshake flags come only from registered pointers, so in_ready never
  // looks through to out_ready and a full FIFO refuses a same-cycle push.
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head word is masked to zero when empty; storage itself is never cleared.
  assign out_data = out_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;

  // Next-state pointers; both wrap naturally modulo 2*DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer registers with synchronous reset; reset-cycle handshakes are lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write at the low bits of the write pointer.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end

`ifdef CHAIN_FIFO_LEVEL_EN
  logic [AW:0] level_q, level_d;

  // Occupancy counter: up on push only, down on pop only.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + PTR_ONE;
      2'b01:   level_d = level_q - PTR_ONE;
      default: level_d = level_q;
    endcase
  end

  // Occupancy register, cleared together with the pointers.
  always_ff @(posedge clk) begin
    if (rst) level_q <= '0;
    else     level_q <= level_d;
  end

  assign level = level_q;
`endif

endmodule
